// File: rtl/start_token_srl_fifo.sv
// Start-token FIFO built on a shift array: every accepted write shifts the array,
// and the oldest token is read through a tap addressed by the registered occupancy.
module start_token_srl_fifo #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 17
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    output logic [ADDR_WIDTH:0]   if_num_data_valid,
    output logic [ADDR_WIDTH:0]   if_fifo_cap
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH + 1)'(1);

    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] sig_q [DEPTH];
    logic [DATA_WIDTH-1:0] sig_d [DEPTH];
    logic [ADDR_WIDTH:0]   count_m1;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  push;
    logic                  pop;

    // Flags and tap address come only from registered count, never from requests.
    assign if_empty_n        = (count_q != '0);
    assign if_full_n         = (count_q != DEPTH_C);
    assign if_num_data_valid = count_q;
    assign if_fifo_cap       = DEPTH_C;

    assign push = if_write & if_write_ce & if_full_n;
    assign pop  = if_read & if_read_ce & if_empty_n;

    always_comb begin
        count_m1 = count_q - ONE_C;
        addr     = '0;
        if (count_q != '0) begin
            addr = count_m1[ADDR_WIDTH-1:0];
        end
    end

    assign if_dout = sig_q[addr];

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_m1;
            default: count_d = count_q;
        endcase
    end

    // Newest token enters at index 0; the tap slides toward it as tokens are popped.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            sig_d[i] = sig_q[i];
        end
        if (push) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                sig_d[i] = sig_q[i-1];
            end
            sig_d[0] = if_din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            sig_q[i] <= sig_d[i];
        end
    end

endmodule

// File: tb/tb_start_token_srl_fifo.sv
// Bench for start_token_srl_fifo: directed scenarios plus random traffic, all
// checked against a queue-based FIFO model.
module tb_start_token_srl_fifo;

    localparam int DEPTH = 17;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       if_write_ce = 1'b0;
    logic       if_write = 1'b0;
    logic [0:0] if_din = '0;
    logic       if_full_n;
    logic       if_read_ce = 1'b0;
    logic       if_read = 1'b0;
    logic [0:0] if_dout;
    logic       if_empty_n;
    logic [5:0] if_num_data_valid;
    logic [5:0] if_fifo_cap;

    int err_cnt = 0;
    int chk_cnt = 0;
    bit model_q[$];

    start_token_srl_fifo dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .if_write_ce       (if_write_ce),
        .if_write          (if_write),
        .if_din            (if_din),
        .if_full_n         (if_full_n),
        .if_read_ce        (if_read_ce),
        .if_read           (if_read),
        .if_dout           (if_dout),
        .if_empty_n        (if_empty_n),
        .if_num_data_valid (if_num_data_valid),
        .if_fifo_cap       (if_fifo_cap)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        assert (if_num_data_valid <= 6'(DEPTH))
        else $error("count out of range: %0d", if_num_data_valid);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".empty_n"}, 32'(if_empty_n), 32'(model_q.size() != 0));
        check({tag, ".full_n"}, 32'(if_full_n), 32'(model_q.size() != DEPTH));
        check({tag, ".count"}, 32'(if_num_data_valid), 32'(model_q.size()));
        if (model_q.size() != 0) begin
            check({tag, ".dout"}, 32'(if_dout), 32'(model_q[0]));
        end
    endtask

    // One clock with the currently driven inputs; model decides acceptance from its own occupancy.
    task automatic step(input string tag);
        bit p, q, d;
        p = if_write && if_write_ce && (model_q.size() < DEPTH);
        q = if_read && if_read_ce && (model_q.size() > 0);
        d = if_din[0];
        @(posedge clk);
        #1;
        if (q) void'(model_q.pop_front());
        if (p) model_q.push_back(d);
        check_outputs(tag);
    endtask

    task automatic drive(input string tag, input logic w, input logic wc, input logic d,
                         input logic r, input logic rc);
        if_write    = w;
        if_write_ce = wc;
        if_din      = d;
        if_read     = r;
        if_read_ce  = rc;
        step(tag);
    endtask

    initial begin
        // Reset then idle
        repeat (3) @(posedge clk);
        #1;
        check("rst.empty_n", 32'(if_empty_n), 0);
        check("rst.full_n", 32'(if_full_n), 1);
        check("rst.count", 32'(if_num_data_valid), 0);
        check("rst.cap", 32'(if_fifo_cap), 17);
        reset_n = 1'b1;
        drive("idle", 0, 0, 0, 0, 0);

        // Single token
        drive("single_push", 1, 1, 1, 0, 0);
        check("single.dout", 32'(if_dout), 1);
        check("single.count", 32'(if_num_data_valid), 1);
        drive("single_pop", 0, 0, 0, 1, 1);
        check("single.empty_after_pop", 32'(if_empty_n), 0);

        // Fill to full, overflow attempt, drain in order
        for (int i = 0; i < DEPTH; i++) drive("fill", 1, 1, 1'((i % 2) == 0), 0, 0);
        check("full.full_n", 32'(if_full_n), 0);
        check("full.count", 32'(if_num_data_valid), 17);
        drive("overflow", 1, 1, 0, 0, 0);
        check("overflow.count", 32'(if_num_data_valid), 17);
        for (int i = 0; i < DEPTH; i++) begin
            check("drain.order", 32'(if_dout), 32'((i % 2) == 0));
            drive("drain", 0, 0, 0, 1, 1);
        end
        check("drain.empty_n", 32'(if_empty_n), 0);
        drive("underflow", 0, 0, 0, 1, 1);
        check("underflow.count", 32'(if_num_data_valid), 0);

        // Simultaneous push/pop at count=5
        for (int i = 0; i < 5; i++) drive("pre5", 1, 1, 1'($urandom_range(0, 1)), 0, 0);
        for (int i = 0; i < 10; i++) drive("pushpop", 1, 1, 1'($urandom_range(0, 1)), 1, 1);
        check("pushpop.count", 32'(if_num_data_valid), 5);

        // Simultaneous push/pop when full pops only
        for (int i = 0; i < 12; i++) drive("refill", 1, 1, 1'($urandom_range(0, 1)), 0, 0);
        check("refill.count", 32'(if_num_data_valid), 17);
        drive("full_pushpop", 1, 1, 1, 1, 1);
        check("full_pushpop.count", 32'(if_num_data_valid), 16);
        check("full_pushpop.full_n", 32'(if_full_n), 1);

        // CE gating
        for (int i = 0; i < 4; i++) drive("ce_gate", 1, 0, 1'($urandom_range(0, 1)), 1, 0);
        check("ce_gate.count", 32'(if_num_data_valid), 16);

        // Drain to 9 then async reset between edges
        for (int i = 0; i < 7; i++) drive("to9", 0, 0, 0, 1, 1);
        check("to9.count", 32'(if_num_data_valid), 9);
        #3 reset_n = 1'b0;
        #1;
        model_q.delete();
        check("async_rst.empty_n", 32'(if_empty_n), 0);
        check("async_rst.full_n", 32'(if_full_n), 1);
        check("async_rst.count", 32'(if_num_data_valid), 0);
        if_write = 1'b0; if_write_ce = 1'b0; if_read = 1'b0; if_read_ce = 1'b0;
        @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("post_rst");
        drive("post_rst_push", 1, 1, 0, 0, 0);
        check("post_rst.dout", 32'(if_dout), 0);
        check("post_rst.count", 32'(if_num_data_valid), 1);

        // Random traffic with write-heavy and read-heavy phases
        for (int ph = 0; ph < 6; ph++) begin
            int wp;
            wp = (ph % 2 == 0) ? 85 : 30;
            for (int i = 0; i < 60; i++) begin
                drive("rand",
                      1'($urandom_range(0, 99) < wp),
                      1'($urandom_range(0, 9) != 0),
                      1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 99) < (100 - wp)),
                      1'($urandom_range(0, 9) != 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
